// File: rtl/twiddle_rotator_stage2.sv
// twiddle_rotator_stage2
//   Stage-2 twiddle consumer for the 256-point pipeline FFT. Counts the
//   stage-2 butterfly outputs, drives the twiddle ROM address/enable, and
//   rotates each sample by the registered cos/sin pair (Q1.12), with
//   round-half-up and saturation. Latency in_valid -> out_valid is 3 cycles.
//
// Ports
//   clk, rst             : clock, synchronous active-high reset
//   in_valid, in_sof     : sample valid, start of frame (qualified by in_valid)
//   in_re, in_im         : signed input sample
//   rd_ptr_angle, en     : twiddle ROM address and read enable (combinational)
//   cos_data, sin_data   : registered ROM words, valid one cycle after en
//   out_valid, out_last  : output valid, last sample of frame (index N-1)
//   out_re, out_im       : rotated, rounded and saturated output sample
module twiddle_rotator_stage2 #(
    parameter int N            = 256,
    parameter int SIZE         = 8,
    parameter int LOG_L        = 2,
    parameter int WIDTH        = 16,
    parameter int bit_width_tw = 14
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    input  logic                           in_sof,
    input  logic signed [WIDTH-1:0]        in_re,
    input  logic signed [WIDTH-1:0]        in_im,
    output logic        [SIZE-4:0]         rd_ptr_angle,
    output logic                           en,
    input  logic signed [bit_width_tw-1:0] cos_data,
    input  logic signed [bit_width_tw-1:0] sin_data,
    output logic                           out_valid,
    output logic                           out_last,
    output logic signed [WIDTH-1:0]        out_re,
    output logic signed [WIDTH-1:0]        out_im
);

    localparam int PW   = WIDTH + bit_width_tw;  // product width
    localparam int SW   = PW + 1;                // sum width
    localparam int FRAC = 12;                    // Q1.12 fraction bits

    localparam logic        [SIZE-1:0] LAST_IDX = SIZE'(N - 1);
    localparam logic signed [SW-1:0]   RND      = SW'(1 << (FRAC - 1));
    localparam logic signed [SW-1:0]   MAXV     = SW'((1 << (WIDTH - 1)) - 1);
    localparam logic signed [SW-1:0]   MINV     = ~MAXV;

    // Frame index
    logic [SIZE-1:0] cnt;
    logic [SIZE-1:0] cidx;

    always_comb begin
        cidx = (in_valid && in_sof) ? '0 : cnt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (in_valid) begin
            cnt <= (cidx == LAST_IDX) ? '0 : cidx + 1'b1;
        end
    end

    // ROM address: entry 1 (-j) for the fourth quarter of every L-block
    always_comb begin
        rd_ptr_angle    = '0;
        rd_ptr_angle[0] = cidx[LOG_L-1] & cidx[LOG_L-2];
    end

    assign en = in_valid;

    // S1: sample aligned with the ROM output
    logic                    v1, last1;
    logic signed [WIDTH-1:0] re1, im1;

    always_ff @(posedge clk) begin
        if (rst) begin
            v1    <= 1'b0;
            last1 <= 1'b0;
            re1   <= '0;
            im1   <= '0;
        end else begin
            v1    <= in_valid;
            last1 <= in_valid && (cidx == LAST_IDX);
            re1   <= in_re;
            im1   <= in_im;
        end
    end

    // S2: four products
    logic                 v2, last2;
    logic signed [PW-1:0] p_rc, p_is, p_rs, p_ic;

    always_ff @(posedge clk) begin
        if (rst) begin
            v2    <= 1'b0;
            last2 <= 1'b0;
            p_rc  <= '0;
            p_is  <= '0;
            p_rs  <= '0;
            p_ic  <= '0;
        end else begin
            v2    <= v1;
            last2 <= last1;
            p_rc  <= PW'(re1) * PW'(cos_data);
            p_is  <= PW'(im1) * PW'(sin_data);
            p_rs  <= PW'(re1) * PW'(sin_data);
            p_ic  <= PW'(im1) * PW'(cos_data);
        end
    end

    // S3: (re + j*im) * (cos + j*sin); the ROM stores sin already negated,
    // so entry 1 (cos=0, sin=-1) rotates by -j.
    logic signed [SW-1:0] sum_re, sum_im, sh_re, sh_im;

    always_comb begin
        sum_re = SW'(p_rc) - SW'(p_is) + RND;
        sum_im = SW'(p_rs) + SW'(p_ic) + RND;
        sh_re  = sum_re >>> FRAC;
        sh_im  = sum_im >>> FRAC;
    end

    function automatic logic signed [WIDTH-1:0] sat(input logic signed [SW-1:0] v);
        if (v > MAXV)
            return {1'b0, {(WIDTH-1){1'b1}}};
        else if (v < MINV)
            return {1'b1, {(WIDTH-1){1'b0}}};
        else
            return v[WIDTH-1:0];
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_re    <= '0;
            out_im    <= '0;
        end else begin
            out_valid <= v2;
            out_last  <= last2;
            if (v2) begin
                out_re <= sat(sh_re);
                out_im <= sat(sh_im);
            end
        end
    end

endmodule

// File: tb/tb_twiddle_rotator_stage2.sv
// tb_twiddle_rotator_stage2
//   Directed bench for twiddle_rotator_stage2 with a two-entry twiddle ROM
//   model. Expected samples are queued when driven and compared when the
//   DUT presents them.
module tb_twiddle_rotator_stage2;

    localparam int N = 256;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_sof = 1'b0;
    logic signed [15:0] in_re = '0;
    logic signed [15:0] in_im = '0;
    logic        [4:0]  rd_ptr_angle;
    logic               en;
    logic signed [13:0] cos_data = '0;
    logic signed [13:0] sin_data = '0;
    logic               out_valid;
    logic               out_last;
    logic signed [15:0] out_re;
    logic signed [15:0] out_im;

    twiddle_rotator_stage2 #(
        .N            (256),
        .SIZE         (8),
        .LOG_L        (2),
        .WIDTH        (16),
        .bit_width_tw (14)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_sof       (in_sof),
        .in_re        (in_re),
        .in_im        (in_im),
        .rd_ptr_angle (rd_ptr_angle),
        .en           (en),
        .cos_data     (cos_data),
        .sin_data     (sin_data),
        .out_valid    (out_valid),
        .out_last     (out_last),
        .out_re       (out_re),
        .out_im       (out_im)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Registered ROM: entry 0 = +1, entry 1 = -j; rom_half forces 0.5
    bit rom_half = 1'b0;
    always @(posedge clk) begin
        if (en) begin
            if (rom_half) begin
                cos_data <= 14'sd2048;
                sin_data <= '0;
            end else if (rd_ptr_angle == 5'd1) begin
                cos_data <= '0;
                sin_data <= -14'sd4096;
            end else begin
                cos_data <= 14'sd4096;
                sin_data <= '0;
            end
        end
    end

    typedef struct {
        int re;
        int im;
        int last;
        int due;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   mcnt  = 0;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int sat16(input longint v);
        if (v > 32767)
            return 32767;
        if (v < -32768)
            return -32768;
        return int'(v);
    endfunction

    // One input cycle: inputs change 2 time units after the rising edge
    task automatic drive(input bit v, input bit sof, input int re, input int im);
        int     idx, c, s, quarter;
        longint pr, pi;
        exp_t   e;
        @(posedge clk);
        #2;
        in_valid = v;
        in_sof   = sof;
        in_re    = 16'(re);
        in_im    = 16'(im);
        #1;
        if (v) begin
            idx     = sof ? 0 : mcnt;
            quarter = (idx % 4 == 3) ? 1 : 0;
            check("addr", int'(rd_ptr_angle), quarter);
            check("en", int'(en), 1);
            if (rom_half) begin
                c = 2048; s = 0;
            end else if (quarter == 1) begin
                c = 0;    s = -4096;
            end else begin
                c = 4096; s = 0;
            end
            pr     = longint'(re) * c - longint'(im) * s;
            pi     = longint'(re) * s + longint'(im) * c;
            e.re   = sat16((pr + 2048) >>> 12);
            e.im   = sat16((pi + 2048) >>> 12);
            e.last = (idx == N - 1) ? 1 : 0;
            e.due  = cyc + 3;
            q.push_back(e);
            mcnt = (idx + 1) % N;
        end else begin
            check("en_idle", int'(en), 0);
        end
    endtask

    task automatic reset_pulse();
        @(posedge clk);
        #2;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        @(posedge clk);
        #2;
        rst  = 1'b0;
        q.delete();
        mcnt = 0;
        #1;
        check("rst_valid", int'(out_valid), 0);
        check("rst_last", int'(out_last), 0);
        check("rst_re", int'(out_re), 0);
        check("rst_im", int'(out_im), 0);
    endtask

    // Output side of the scoreboard
    exp_t ce;
    always @(negedge clk) begin
        if (out_valid) begin
            if (q.size() == 0) begin
                check("spurious_valid", 1, 0);
            end else begin
                ce = q.pop_front();
                check("out_re", int'(out_re), ce.re);
                check("out_im", int'(out_im), ce.im);
                check("out_last", int'(out_last), ce.last);
                check("latency_cycle", cyc, ce.due);
            end
        end else begin
            check("last_idle", int'(out_last), 0);
            if (q.size() > 0 && q[0].due <= cyc) begin
                check("missing_valid", 0, 1);
                ce = q.pop_front();
            end
        end
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("init_valid", int'(out_valid), 0);
        check("init_last", int'(out_last), 0);
        check("init_re", int'(out_re), 0);
        check("init_im", int'(out_im), 0);

        // 8 samples of (1000, 500): +1 x3 then -j
        for (int i = 0; i < 8; i++) drive(1'b1, i == 0, 1000, 500);
        drive(1'b0, 1'b0, 0, 0);

        // -j saturation at index 3
        drive(1'b1, 1'b1, 0, 0);
        drive(1'b1, 1'b0, 10, -10);
        drive(1'b1, 1'b0, -7, 7);
        drive(1'b1, 1'b0, -32768, -32768);
        drive(1'b0, 1'b0, 0, 0);

        // Rounding with a 0.5 twiddle
        drive(1'b0, 1'b0, 0, 0);
        rom_half = 1'b1;
        drive(1'b1, 1'b1, 3, -3);
        drive(1'b1, 1'b0, -3, 3);
        drive(1'b0, 1'b0, 0, 0);
        rom_half = 1'b0;
        drive(1'b0, 1'b0, 0, 0);

        // Full frame, then continuation without sof starts at index 0
        for (int i = 0; i < N; i++)
            drive(1'b1, i == 0, int'($urandom_range(0, 65535)) - 32768,
                  int'($urandom_range(0, 65535)) - 32768);
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 100 * i, -50 * i);
        drive(1'b0, 1'b0, 0, 0);

        // Gaps: valid on even cycles, sof on sample 6 and on one idle cycle
        for (int i = 0; i < 24; i++) begin
            if (i % 2 == 0)
                drive(1'b1, (i / 2) == 6, int'($urandom_range(0, 65535)) - 32768,
                      int'($urandom_range(0, 65535)) - 32768);
            else
                drive(1'b0, i == 9, 0, 0);
        end
        drive(1'b0, 1'b0, 0, 0);

        // Reset after sample 5 of a frame, then resume without sof
        for (int i = 0; i < 6; i++) drive(1'b1, i == 0, 200 + i, -300 - i);
        reset_pulse();
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1234, -4321);
        repeat (6) drive(1'b0, 1'b0, 0, 0);

        check("drain_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
